div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DIV_ITERS, default 32, number of radix-2 iterations per division.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  divide instruction present in E stage (div_signalE).
REQ-005 SHALL have port signed_div  input  1  1 = DIV, 0 = DIVU; sampled with start.
REQ-006 SHALL have port opa  input  32  dividend (rs value after E forwarding).
REQ-007 SHALL have port opb  input  32  divisor (rt value after E forwarding).
REQ-008 SHALL have port annul  input  1  pipeline flush (flush_except); abandons the operation.
REQ-009 SHALL have port stall_div  output  1  holds F/D/E/M while a division is in progress (stall_divE).
REQ-010 SHALL have port result_valid  output  1  one-cycle strobe: hi/lo hold the new result.
REQ-011 SHALL have port hi  output  32  remainder.
REQ-012 SHALL have port lo  output  32  quotient.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 and annul=0 -> latch |opa|, |opb|, the quotient sign (signs differ, signed only) and the remainder sign (dividend sign, signed only); clear iteration count; go to RUN.
REQ-015 RUN: one restoring shift-subtract step per cycle, count increments; after step DIV_ITERS-1 -> DONE.
REQ-016 DONE: apply sign corrections, register hi/lo, assert result_valid for exactly this cycle, go to IDLE.
REQ-017 stall_div SHALL be combinational: (IDLE & start & ~annul) | RUN; 0 in DONE and whenever annul=1.
REQ-018 Latency: start accepted in cycle 0 -> stall_div high cycles 0..DIV_ITERS (33 cycles at default), result_valid and stall_div=0 in cycle DIV_ITERS+1.
REQ-019 start still high in the DONE cycle SHALL NOT begin a new division; start seen in the following IDLE cycle SHALL (back-to-back divides).
REQ-020 annul=1 in any state -> IDLE next cycle; no result_valid; hi/lo unchanged.
REQ-021 Divisor zero: no exception; quotient magnitude 0xFFFFFFFF, remainder magnitude = |dividend|, signs per REQ-014.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
REQ-023 Operand magnitudes SHALL be 32-bit unsigned (|0x80000000| = 0x80000000); the partial remainder register SHALL be 33 bits.
REQ-024 hi/lo SHALL change only in DONE and hold until the next DONE.
REQ-025 opa/opb/signed_div changes after the accept cycle SHALL NOT affect the result.

Reset
REQ-026 rst=1 -> state IDLE, count 0, hi=0, lo=0, result_valid=0, stall_div=0 (including while start=1), taking priority over annul and start.
REQ-027 rst during RUN SHALL discard the operation with no result_valid.

Structure
REQ-028 The state enumeration and DIV_ITERS default SHALL live in the shared cpu_pkg package.
REQ-029 SHALL be a single module with no sub-module; the shift-subtract step is inline logic.

Verification
REQ-030 DIVU 100/7 -> stall_div high 33 cycles, then result_valid=1 for 1 cycle with lo=14, hi=2.
REQ-031 DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 -> lo=-3, hi=1.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-033 annul pulse at RUN cycle 10 -> stall_div=0 in that cycle, IDLE next cycle, no result_valid, hi/lo keep prior values.
REQ-034 Two back-to-back divides (start held) -> two result_valid strobes 34 cycles apart with correct values; DONE cycle shows stall_div=0.
REQ-035 rst at RUN cycle 5 with start held high -> stall_div=0 during reset, outputs zero, a fresh 33-cycle division after rst drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the sequential divider's state encoding and iteration count.
package cpu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

    localparam int DIV_ITERS_DEFAULT = 32;

    // Magnitude of a 32-bit operand; |0x80000000| stays 0x80000000 as an unsigned value.
    function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: one shift-subtract step per cycle,
// stalls the front of the pipeline while busy and strobes hi/lo when finished.
module div_seq
    import cpu_pkg::*;
#(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        annul,
    output logic        stall_div,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(DIV_ITERS + 1);

    divState_t      state;
    logic [CW-1:0]  count;
    logic [32:0]    rem;
    logic [31:0]    quo;
    logic [31:0]    dvsr;
    logic           negQ;
    logic           negR;
    logic           resultValid;

    logic [33:0]    shifted;
    logic [33:0]    diff;
    logic [32:0]    remNext;
    logic [31:0]    quoNext;
    logic [31:0]    remMag;

    // Quotient bits enter from the right while dividend bits shift out of quo into rem.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {2'b00, dvsr};
        if (shifted >= {2'b00, dvsr}) begin
            remNext = 33'(diff);
            quoNext = {quo[30:0], 1'b1};
        end else begin
            remNext = 33'(shifted);
            quoNext = {quo[30:0], 1'b0};
        end
        remMag = 32'(remNext);
    end

    assign stall_div    = ~rst & ~annul &
                          (((state == DIV_IDLE) & start) | (state == DIV_RUN));
    assign result_valid = resultValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DIV_IDLE;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            resultValid <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
        end else begin
            resultValid <= 1'b0;
            if (annul) begin
                state <= DIV_IDLE;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start) begin
                            quo   <= absVal(opa, signed_div);
                            dvsr  <= absVal(opb, signed_div);
                            rem   <= '0;
                            negQ  <= signed_div & (opa[31] ^ opb[31]);
                            negR  <= signed_div & opa[31];
                            count <= '0;
                            state <= DIV_RUN;
                        end
                    end
                    DIV_RUN: begin
                        rem   <= remNext;
                        quo   <= quoNext;
                        count <= count + 1'b1;
                        // Results land on entry to DONE so they are visible alongside the strobe.
                        if (count == CW'(DIV_ITERS - 1)) begin
                            lo          <= negQ ? (~quoNext + 32'd1) : quoNext;
                            hi          <= negR ? (~remMag + 32'd1) : remMag;
                            resultValid <= 1'b1;
                            state       <= DIV_DONE;
                        end
                    end
                    default: state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, random operands against a
// plain-arithmetic reference, and annul / back-to-back / reset sequences.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall_div;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int nChecks = 0;
    int nPass   = 0;

    div_seq #(.DIV_ITERS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opa(opa), .opb(opb), .annul(annul), .stall_div(stall_div),
        .result_valid(result_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Reference: MIPS DIV/DIVU semantics via 64-bit integer arithmetic.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = (s && a[31]) ? 32'd1 : 32'hFFFFFFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Called just after the accept cycle's negedge; runs to the strobe and checks it.
    task automatic waitDone(input string nm, input logic [31:0] q, input logic [31:0] r,
                            input int stall0, input bit holdStart);
        int cyc;
        int stalls;
        stalls = stall0;
        @(negedge clk);
        if (!holdStart) start = 1'b0;
        opa = $urandom; opb = $urandom; signed_div = 1'($urandom);
        #1;
        cyc = 1;
        while (!result_valid && cyc < 45) begin
            if (stall_div) stalls++;
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'd33);
        chk({nm, " stall_cycles"}, 32'(stalls), 32'd33);
        chk({nm, " done_stall"}, {31'd0, stall_div}, 32'd0);
        chk({nm, " lo"}, lo, q);
        chk({nm, " hi"}, hi, r);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk({nm, " strobe_width"}, {31'd0, result_valid}, 32'd0);
    endtask

    task automatic runOne(input string nm, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
        int st0;
        @(negedge clk);
        start = 1'b1; signed_div = s; opa = a; opb = b;
        #1;
        st0 = stall_div ? 1 : 0;
        waitDone(nm, q, r, st0, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] mq, mr, pHi, pLo, a1, b1, a2, b2, q1, r1, q2, r2;
        logic [31:0] sHi[2], sLo[2];
        int sCyc[2];
        int nStrobe, rvCount, st0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[4] = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
        vecs[5] = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'd1,          32'hFFFFFFFB};
        vecs[6] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[8] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0};

        rst = 1'b1; start = 1'b1; signed_div = 1'b0; opa = 32'd9; opb = 32'd3; annul = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", {31'd0, stall_div}, 32'd0);
        chk("reset valid", {31'd0, result_valid}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 9; i++)
            runOne($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

        for (int i = 0; i < 20; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom);
            a = $urandom;
            b = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : ((i % 3 == 0) ? (32'($urandom) >> 20) : $urandom);
            model(s, a, b, mq, mr);
            runOne($sformatf("rand%0d", i), s, a, b, mq, mr);
        end

        // Annul in the middle of RUN.
        pHi = hi; pLo = lo;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        annul = 1'b1;
        #1;
        chk("annul stall", {31'd0, stall_div}, 32'd0);
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("annul idle_stall", {31'd0, stall_div}, 32'd0);
        rvCount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid) rvCount++;
        end
        chk("annul no_strobe", 32'(rvCount), 32'd0);
        chk("annul hi_kept", hi, pHi);
        chk("annul lo_kept", lo, pLo);

        // Back-to-back with start held; operands switch after the first accept.
        a1 = 32'hFFFFFF9C; b1 = 32'd7; a2 = 32'd123456789; b2 = 32'hFFFFFC19;
        model(1'b1, a1, b1, q1, r1);
        model(1'b1, a2, b2, q2, r2);
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; opa = a1; opb = b1;
        nStrobe = 0;
        for (int c = 1; c < 90 && nStrobe < 2; c++) begin
            @(negedge clk);
            opa = a2; opb = b2;
            #1;
            if (result_valid) begin
                chk($sformatf("b2b done_stall%0d", nStrobe), {31'd0, stall_div}, 32'd0);
                sCyc[nStrobe] = c; sHi[nStrobe] = hi; sLo[nStrobe] = lo;
                nStrobe++;
            end
        end
        start = 1'b0;
        chk("b2b strobes", 32'(nStrobe), 32'd2);
        if (nStrobe == 2) begin
            chk("b2b first_at", 32'(sCyc[0]), 32'd33);
            chk("b2b gap", 32'(sCyc[1] - sCyc[0]), 32'd34);
            chk("b2b lo0", sLo[0], q1);
            chk("b2b hi0", sHi[0], r1);
            chk("b2b lo1", sLo[1], q2);
            chk("b2b hi1", sHi[1], r2);
        end
        repeat (3) @(negedge clk);

        // Reset during RUN with start held high, then a fresh division.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opa = 32'd77; opb = 32'd5;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst stall", {31'd0, stall_div}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst stall_held", {31'd0, stall_div}, 32'd0);
        chk("rst valid", {31'd0, result_valid}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        rst = 1'b0; signed_div = 1'b0; opa = 32'd1000; opb = 32'd33;
        #1;
        st0 = stall_div ? 1 : 0;
        waitDone("post_rst", 32'd30, 32'd10, st0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
